port_uart_tx: RTL
=================

PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit (legal range 2..1023).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of 16-bit words buffered (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port out_port, input, 16, the CPU output word.
REQ-006 The block SHALL have port output_valid, input, 1, a one-cycle strobe marking out_port as a new word.
REQ-007 The block SHALL have port tx, output, 1, the serial line, idle high.
REQ-008 The block SHALL have port status, output, 16, CPU-readable status {13'b0, overflow, full, busy}, for muxing onto the CPU in_port.

Function
REQ-009 Each cycle with output_valid=1 and FIFO not full SHALL write out_port into the FIFO at that rising edge.
REQ-010 With output_valid=1 and FIFO full, the word SHALL be dropped and overflow set; overflow is sticky until rst.
REQ-011 A push and a pop in the same cycle on a full FIFO SHALL be accepted (count unchanged, no overflow).
REQ-012 The transmit FSM SHALL have states IDLE, START, DATA, STOP, plus a byte_sel bit (0=low byte, 1=high byte).
REQ-013 In IDLE with FIFO non-empty, the FSM SHALL pop the head word into a 16-bit shift holding register, clear byte_sel, and go to START at that edge.
REQ-014 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA SHALL send bits 0..7 of the selected byte, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
REQ-016 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; then if byte_sel=0, set byte_sel=1 and go to START; else go to IDLE.
REQ-017 tx SHALL be a registered output; IDLE drives tx=1.
REQ-018 Latency: a strobe in cycle N to an idle, empty block SHALL produce tx falling to 0 at the edge ending cycle N+1 (pop edge), visible from cycle N+2.
REQ-019 One word SHALL occupy exactly 20*CLKS_PER_BIT cycles; low and high bytes are back to back; at least one IDLE cycle separates words.
REQ-020 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 busy SHALL be 1 when the FSM is not IDLE or the FIFO is non-empty; full SHALL be 1 when the FIFO count equals FIFO_DEPTH.
REQ-022 status SHALL be combinational from registered state; bits 15:3 are always 0.

Reset
REQ-023 On rst=1 at a rising edge: FSM to IDLE, tx=1, byte_sel=0, counters 0, FIFO emptied, overflow=0; thus status=16'h0000.
REQ-024 Reset mid-frame SHALL abort the frame immediately (tx=1 from the next cycle) and discard all buffered words.
REQ-025 output_valid during a cycle with rst=1 SHALL be ignored.

Structure
REQ-026 FSM state enum and status bit-index constants SHALL live in a shared package, port_uart_pkg.
REQ-027 The FIFO SHALL be a separate sub-module, word_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single word: strobe 16'hA55A once -> tx low from cycle N+2; serial bits 0,0x5A LSB-first,1,0,0xA5 LSB-first,1 each 4 cycles; busy clears after 80+1 cycles.
REQ-029 Back-to-back: strobe 16'h0001,16'h0002 consecutive cycles -> two 80-cycle frames separated by exactly one idle cycle, bytes 01,00,02,00.
REQ-030 Overflow: 6 strobes on consecutive cycles from idle -> first popped, next 4 buffered, 6th dropped; status=16'h0007 after, 5 words transmitted.
REQ-031 Full push+pop: fill FIFO to 4 while transmitting, strobe on the pop cycle -> word accepted, overflow stays 0.
REQ-032 Mid-frame reset: rst for one cycle during DATA of first byte with 2 words queued -> tx=1 next cycle, status=16'h0000, no further frames.
REQ-033 Reset strobe: output_valid=1 in a rst cycle -> nothing buffered, tx stays 1.

Source files
------------

// File: rtl/port_uart_pkg.sv
// Shared definitions for the UART word transmitter.
// Contents:
//   state_t          - 2-bit transmit FSM state type
//   ST_*             - FSM state encodings (IDLE, START, DATA, STOP)
//   STATUS_*         - bit positions inside the 16-bit CPU status word
package port_uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam int STATUS_BUSY     = 0;
    localparam int STATUS_FULL     = 1;
    localparam int STATUS_OVERFLOW = 2;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO of WIDTH-bit words, DEPTH entries (power of two).
// Ports:
//   clk, rst      - clock, synchronous active-high reset (empties the FIFO)
//   push, din     - write request and data; accepted when not full, or when
//                   full but a pop happens in the same cycle
//   pop, dout     - read request; dout always shows the head word
//   full, empty   - occupancy flags
//   count         - number of stored words, 0..DEPTH
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    // Head word is presented combinationally so the consumer can load it
    // at the same edge that pops it.
    assign dout  = mem[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/port_uart_tx.sv
// CPU output port to UART transmitter. Each 16-bit word written by the CPU
// is buffered in a FIFO and sent as two 8N1 characters, low byte first.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   out_port      - CPU output word
//   output_valid  - one-cycle strobe: out_port holds a new word
//   tx            - registered serial line, idle high
//   status        - {13'b0, overflow, full, busy} for the CPU input mux
module port_uart_tx
    import port_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] out_port,
    input  logic        output_valid,
    output logic        tx,
    output logic [15:0] status
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST        = CW'(CLKS_PER_BIT - 1);
    localparam logic [FAW:0]  FIFO_FULL_COUNT = (FAW+1)'(FIFO_DEPTH);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [2:0]    bit_next;
    logic          byte_sel_reg;
    logic [15:0]   shift_reg;
    logic          tx_reg;
    logic          overflow_reg;

    logic [15:0]   fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FAW:0]  fifo_count;
    logic          pop;
    logic          bit_done;
    logic          busy;
    logic          full;

    assign pop      = (state_reg == ST_IDLE) && !fifo_empty;
    assign bit_done = (cnt_reg == CNT_LAST);
    assign bit_next = bit_idx_reg + 3'd1;

    word_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (output_valid),
        .din   (out_port),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bit-period counter: free-runs 0..CLKS_PER_BIT-1 in every non-idle state.
    always_ff @(posedge clk) begin
        if (rst || state_reg == ST_IDLE || bit_done) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // tx is loaded with the level of the *next* bit at each transition so the
    // line changes exactly on bit boundaries without an extra output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            tx_reg       <= 1'b1;
            byte_sel_reg <= 1'b0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            // A pop this cycle frees a slot, so a full FIFO only drops
            // the word when nothing leaves.
            if (output_valid && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg    <= fifo_dout;
                        byte_sel_reg <= 1'b0;
                        state_reg    <= ST_START;
                        tx_reg       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        bit_idx_reg <= '0;
                        state_reg   <= ST_DATA;
                        tx_reg      <= shift_reg[{byte_sel_reg, 3'd0}];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_next;
                            tx_reg      <= shift_reg[{byte_sel_reg, bit_next}];
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (!byte_sel_reg) begin
                            byte_sel_reg <= 1'b1;
                            state_reg    <= ST_START;
                            tx_reg       <= 1'b0;
                        end else begin
                            state_reg <= ST_IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE) || !fifo_empty;
    assign full = (fifo_count == FIFO_FULL_COUNT);
    assign tx   = tx_reg;

    always_comb begin
        status                  = 16'h0000;
        status[STATUS_BUSY]     = busy;
        status[STATUS_FULL]     = full;
        status[STATUS_OVERFLOW] = overflow_reg;
    end

endmodule
